// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-to-log2(N) request encoder, fixed or round-robin priority,
// with a registered result behind a valid/ready handshake.
module prio_encoder_rr #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   input  logic         rr_mode_i,
   input  logic         out_ready_i,
   output logic         out_valid_o,
   output logic [W-1:0] out_idx_o,
   output logic [N-1:0] out_onehot_o,
   output logic         out_multi_o,
   output logic [W-1:0] rr_ptr_o
);
   logic           valid_q, valid_d;
   logic [W-1:0]   idx_q, idx_d;
   logic [N-1:0]   onehot_q, onehot_d;
   logic           multi_q, multi_d;
   logic [W-1:0]   ptr_q, ptr_d;
   logic [W-1:0]   fix_idx, rr_off, win;
   logic [2*N-1:0] rot;
   logic           found, load;
   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++)
         if (req_i[i]) fix_idx = W'(i);
      // rotate so rr_ptr lands at bit 0; the lowest set bit is then the next in turn
      rot = {req_i, req_i} >> ptr_q;
      rr_off = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++)
         if (rot[i] && !found) begin
            rr_off = W'(i);
            found = 1'b1;
         end
      win = rr_mode_i ? ptr_q + rr_off : fix_idx;
      load = en_i && (req_i != '0) && (!valid_q || out_ready_i);
      valid_d = load ? 1'b1 : (valid_q && !out_ready_i);
      idx_d = load ? win : idx_q;
      onehot_d = load ? N'(1) << win : onehot_q;
      multi_d = load ? |(req_i & (req_i - N'(1))) : multi_q;
      ptr_d = (load && rr_mode_i) ? win + W'(1) : ptr_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid_q <= 1'b0;
         idx_q <= '0;
         onehot_q <= '0;
         multi_q <= 1'b0;
         ptr_q <= '0;
      end else begin
         valid_q <= valid_d;
         idx_q <= idx_d;
         onehot_q <= onehot_d;
         multi_q <= multi_d;
         ptr_q <= ptr_d;
      end
   assign out_valid_o = valid_q;
   assign out_idx_o = idx_q;
   assign out_onehot_o = onehot_q;
   assign out_multi_o = multi_q;
   assign rr_ptr_o = ptr_q;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: directed vectors with hand-computed expectations for prio_encoder_rr.
module tb_prio_encoder_rr;
   logic       clk = 0;
   logic       rst_n = 0;
   logic [7:0] req = 0;
   logic       en = 0;
   logic       rr_mode = 0;
   logic       out_ready = 0;
   logic       out_valid;
   logic [2:0] out_idx;
   logic [7:0] out_onehot;
   logic       out_multi;
   logic [2:0] rr_ptr;
   int         checks = 0;
   int         errors = 0;
   prio_encoder_rr #(.N(8), .W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en), .rr_mode_i(rr_mode),
      .out_ready_i(out_ready), .out_valid_o(out_valid), .out_idx_o(out_idx),
      .out_onehot_o(out_onehot), .out_multi_o(out_multi), .rr_ptr_o(rr_ptr)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic result(input string tag, input logic v, input logic [2:0] i, input logic m, input logic [2:0] p);
      check({tag, "_valid"}, out_valid, v);
      check({tag, "_idx"}, out_idx, i);
      check({tag, "_onehot"}, out_onehot, v ? 8'h01 << i : out_onehot);
      check({tag, "_multi"}, out_multi, m);
      check({tag, "_ptr"}, rr_ptr, p);
   endtask
   initial begin
      #3;
      check("rst_valid", out_valid, 0);
      check("rst_idx", out_idx, 0);
      check("rst_onehot", out_onehot, 0);
      check("rst_multi", out_multi, 0);
      check("rst_ptr", rr_ptr, 0);
      rst_n = 1;
      step();
      check("idle_valid", out_valid, 0);
      en = 1; out_ready = 1;
      req = 8'b0010_0110;
      step();
      result("fix1", 1, 5, 1, 0);
      check("fix1_onehot_abs", out_onehot, 8'h20);
      req = 8'h01;
      step();
      result("fix2", 1, 0, 0, 0);
      req = 8'h20;
      step();
      result("pre_rst", 1, 5, 0, 0);
      #2 rst_n = 0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_idx", out_idx, 0);
      check("arst_onehot", out_onehot, 0);
      check("arst_multi", out_multi, 0);
      check("arst_ptr", rr_ptr, 0);
      req = 0;
      @(negedge clk);
      rst_n = 1;
      step();
      check("post_rst_valid", out_valid, 0);
      rr_mode = 1; req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         step();
         result($sformatf("rr%0d", k), 1, 3'(k % 8), 1, 3'((k + 1) % 8));
      end
      req = 8'h20;
      step();
      result("rr_set6", 1, 5, 0, 6);
      req = 8'h03;
      step();
      result("wrap1", 1, 0, 1, 1);
      step();
      result("wrap2", 1, 1, 1, 2);
      req = 8'h08;
      step();
      result("bp_load", 1, 3, 0, 4);
      out_ready = 0;
      for (int k = 0; k < 4; k++) begin
         req = k[0] ? 8'h10 : 8'h80;
         step();
         result($sformatf("bp%0d", k), 1, 3, 0, 4);
      end
      out_ready = 1; req = 8'h80;
      step();
      result("bp_rel", 1, 7, 0, 0);
      req = 0;
      step();
      check("drain_valid", out_valid, 0);
      check("drain_idx", out_idx, 7);
      en = 0; req = 8'h04;
      step();
      check("en0_valid_a", out_valid, 0);
      step();
      check("en0_valid_b", out_valid, 0);
      en = 1;
      step();
      result("en1", 1, 2, 0, 3);
      rr_mode = 0; req = 8'h05;
      step();
      result("sw_fix", 1, 2, 1, 3);
      rr_mode = 1;
      step();
      result("sw_rr", 1, 0, 1, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
